cache_refill_engine: RTL

- Miss-handling stage downstream of the cache set array.
- On a miss it writes back the dirty victim line (when required), then fetches the new line from memory.
- Transfers use a single-beat 32-bit req/ack memory port; the 128-bit line is assembled and returned as a one-cycle fill for the cache's load path.
- One miss in flight at a time.

---
 rtl/cache_refill_engine_if.sv | 33 +++
 rtl/cache_refill_engine.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cache_refill_engine_if.sv
// Bundle of the miss/fill handshake and the single-beat memory port of cache_refill_engine.
// master = cache/memory side, slave = the refill engine.
interface cache_refill_engine_if #(
   parameter int ADDR_W    = 32,
   parameter int LINE_BITS = 128
);
   logic                 miss_valid;
   logic                 miss_ready;
   logic [ADDR_W-1:0]    miss_addr;
   logic [ADDR_W-1:0]    miss_victim_addr;
   logic                 miss_dirty;
   logic [LINE_BITS-1:0] miss_wbdata;
   logic                 fill_valid;
   logic [ADDR_W-1:0]    fill_addr;
   logic [LINE_BITS-1:0] fill_data;
   logic                 busy;
   logic                 mem_req;
   logic                 mem_we;
   logic [ADDR_W-1:0]    mem_addr;
   logic [31:0]          mem_wdata;
   logic [31:0]          mem_rdata;
   logic                 mem_ack;

   modport master (
      output miss_valid, miss_addr, miss_victim_addr, miss_dirty, miss_wbdata, mem_rdata, mem_ack,
      input  miss_ready, fill_valid, fill_addr, fill_data, busy, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  miss_valid, miss_addr, miss_victim_addr, miss_dirty, miss_wbdata, mem_rdata, mem_ack,
      output miss_ready, fill_valid, fill_addr, fill_data, busy, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_refill_engine.sv
// Cache miss refill engine: optional dirty-victim write-back, then a 4-beat line fetch returned as a one-cycle fill.
// Define CACHE_REFILL_CWF_EN for critical-word-first read ordering.
module cache_refill_engine #(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 16,
   parameter int LINE_BITS  = LINE_BYTES * 8
) (
   input logic                  clk,
   input logic                  rst,
   cache_refill_engine_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_DONE} state_t;

   state_t               r_state;
   logic [1:0]           r_beat;
   logic [1:0]           r_w0;
   logic [ADDR_W-1:0]    r_line_base;
   logic [ADDR_W-1:0]    r_vic_base;
   logic [LINE_BITS-1:0] r_wbdata;
   logic [LINE_BITS-1:0] r_buf;
   logic                 r_mem_req;
   logic                 r_mem_we;
   logic [ADDR_W-1:0]    r_mem_addr;
   logic [31:0]          r_mem_wdata;
   logic                 r_fill_valid;
   logic [ADDR_W-1:0]    r_fill_addr;
   logic [LINE_BITS-1:0] r_fill_data;

   logic [ADDR_W-1:0]    w_line_base;
   logic [ADDR_W-1:0]    w_vic_base;
   logic [1:0]           w_beat_inc;
   logic [1:0]           w_w0;
   logic                 w_rd_last;
   logic [LINE_BITS-1:0] w_buf_upd;

   function automatic logic [ADDR_W-1:0] beat_off(input logic [1:0] b);
      beat_off      = '0;
      beat_off[3:2] = b;
   endfunction

   assign w_line_base = bus.miss_addr        & ~ADDR_W'(LINE_BYTES - 1);
   assign w_vic_base  = bus.miss_victim_addr & ~ADDR_W'(LINE_BYTES - 1);
   assign w_beat_inc  = r_beat + 2'd1;

`ifdef CACHE_REFILL_CWF_EN
   assign w_w0 = bus.miss_addr[3:2];
`else
   assign w_w0 = 2'b00;
`endif

   // The read burst wraps back to its starting word, so the last beat is the one before r_w0.
   assign w_rd_last = (w_beat_inc == r_w0);

   always_comb begin
      w_buf_upd                          = r_buf;
      w_buf_upd[int'(r_beat)*32 +: 32]   = bus.mem_rdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_beat       <= '0;
         r_w0         <= '0;
         r_line_base  <= '0;
         r_vic_base   <= '0;
         r_wbdata     <= '0;
         r_buf        <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_fill_valid <= 1'b0;
         r_fill_addr  <= '0;
         r_fill_data  <= '0;
      end else begin
         r_fill_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.miss_valid) begin
                  r_line_base <= w_line_base;
                  r_vic_base  <= w_vic_base;
                  r_wbdata    <= bus.miss_wbdata;
                  r_w0        <= w_w0;
                  r_mem_req   <= 1'b1;
                  if (bus.miss_dirty) begin
                     r_state     <= S_WB;
                     r_beat      <= 2'd0;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= w_vic_base;
                     r_mem_wdata <= bus.miss_wbdata[31:0];
                  end else begin
                     r_state     <= S_RD;
                     r_beat      <= w_w0;
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= w_line_base + beat_off(w_w0);
                     r_mem_wdata <= '0;
                  end
               end
            end
            S_WB: begin
               if (bus.mem_ack) begin
                  if (r_beat == 2'd3) begin
                     r_state     <= S_RD;
                     r_beat      <= r_w0;
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= r_line_base + beat_off(r_w0);
                     r_mem_wdata <= '0;
                  end else begin
                     r_beat      <= w_beat_inc;
                     r_mem_addr  <= r_vic_base + beat_off(w_beat_inc);
                     r_mem_wdata <= r_wbdata[int'(w_beat_inc)*32 +: 32];
                  end
               end
            end
            S_RD: begin
               if (bus.mem_ack) begin
                  r_buf <= w_buf_upd;
                  if (w_rd_last) begin
                     // The fill carries the merged buffer so the final beat is included.
                     r_state      <= S_DONE;
                     r_beat       <= 2'd0;
                     r_mem_req    <= 1'b0;
                     r_fill_valid <= 1'b1;
                     r_fill_addr  <= r_line_base;
                     r_fill_data  <= w_buf_upd;
                  end else begin
                     r_beat     <= w_beat_inc;
                     r_mem_addr <= r_line_base + beat_off(w_beat_inc);
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.miss_ready = rst && (r_state == S_IDLE);
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.mem_req    = r_mem_req;
   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.fill_valid = r_fill_valid;
   assign bus.fill_addr  = r_fill_addr;
   assign bus.fill_data  = r_fill_data;
endmodule
